control_sequencer: RTL

//   Sequencing half of the control unit, directly upstream of the per-format instruction decoders.
//   - Fetches the instruction word into an instruction register (IR).
//   - Tracks the execute sub-state and holds the status flags.
//   - Presents IR/state/status to the decoders.
//   - Selects the decoder control word (CW) for the current opcode class.
//   - Gates the selected CW against memory stalls before it reaches the datapath.

---
 rtl/control_pkg.sv | 74 +++++++
 rtl/control_sequencer_cw_gate.sv | 25 ++
 rtl/control_sequencer.sv | 138 +++++++++++++
 3 files changed

// File: rtl/control_pkg.sv
// Shared definitions for the control sequencer: control-word field positions,
// pc_fs encodings, decoder class codes, the FETCH control word and the
// opcode classifier used to pick a decoder.
package control_pkg;

  // Control-word field positions (33-bit word).
  localparam int CW_ALU_EN    = 32;
  localparam int CW_ALU_BS    = 31;
  localparam int CW_ALU_FS_HI = 30;
  localparam int CW_ALU_FS_LO = 26;
  localparam int CW_RF_B_EN   = 25;
  localparam int CW_RF_SA_HI  = 24;
  localparam int CW_RF_SA_LO  = 20;
  localparam int CW_RF_SB_HI  = 19;
  localparam int CW_RF_SB_LO  = 15;
  localparam int CW_RF_DA_HI  = 14;
  localparam int CW_RF_DA_LO  = 10;
  localparam int CW_RF_W      = 9;
  localparam int CW_RAM_EN    = 8;
  localparam int CW_RAM_W     = 7;
  localparam int CW_PC_EN     = 6;
  localparam int CW_PC_FS_HI  = 5;
  localparam int CW_PC_FS_LO  = 4;
  localparam int CW_PC_IS     = 3;
  localparam int CW_STATUS_LD = 2;
  localparam int CW_NS_HI     = 1;
  localparam int CW_NS_LO     = 0;

  // Program-counter function select.
  localparam logic [1:0] PC_FS_HOLD = 2'b00;
  localparam logic [1:0] PC_FS_INC  = 2'b01;
  localparam logic [1:0] PC_FS_LOAD = 2'b10;
  localparam logic [1:0] PC_FS_REL  = 2'b11;

  // Decoder classes; ILLEGAL is not backed by a decoder.
  localparam logic [2:0] CLS_B       = 3'd0;
  localparam logic [2:0] CLS_BL      = 3'd1;
  localparam logic [2:0] CLS_CB      = 3'd2;
  localparam logic [2:0] CLS_D       = 3'd3;
  localparam logic [2:0] CLS_I       = 3'd4;
  localparam logic [2:0] CLS_R       = 3'd5;
  localparam logic [2:0] CLS_ILLEGAL = 3'd7;

  // Instruction fetch: ram_en=1, rf_sa=rf_sb=31, alu_fs=11111, everything else 0.
  localparam logic [32:0] FETCH_CW = {1'b0, 1'b0, 5'b11111, 1'b0, 5'd31, 5'd31,
                                      5'd0, 1'b0, 1'b1, 1'b0, 1'b0, PC_FS_HOLD,
                                      1'b0, 1'b0, 2'b00};
  // Trap word: the fetch word with the memory request withdrawn.
  localparam logic [32:0] HALT_CW  = {1'b0, 1'b0, 5'b11111, 1'b0, 5'd31, 5'd31,
                                      5'd0, 1'b0, 1'b0, 1'b0, 1'b0, PC_FS_HOLD,
                                      1'b0, 1'b0, 2'b00};

  // Opcode classifier; the first matching pattern wins.
  function automatic logic [2:0] op_class(input logic [31:0] instr);
    logic [2:0] c;
    if (instr[31:26] == 6'b000101)
      c = CLS_B;
    else if (instr[31:26] == 6'b100101)
      c = CLS_BL;
    else if (instr[31:25] == 7'b1011010 || instr[31:25] == 7'b1011011 ||
             instr[31:25] == 7'b0101010)
      c = CLS_CB;
    else if (instr[29:27] == 3'b111 && !instr[25])
      c = CLS_D;
    else if (instr[28:26] == 3'b100)
      c = CLS_I;
    else if (instr[27:25] == 3'b101)
      c = CLS_R;
    else
      c = CLS_ILLEGAL;
    return c;
  endfunction

endpackage

// File: rtl/control_sequencer_cw_gate.sv
// cw_gate: suppresses the architectural side effects of a control word while
// the memory is stalling it. Register write, status load and PC update are
// masked; the memory request (ram_en/ram_w) stays asserted so the access
// keeps being presented until the memory accepts it.
module cw_gate
  import control_pkg::*;
#(
  parameter int CW_W = 33
) (
  input  logic [CW_W-1:0] raw,
  input  logic            stall,
  output logic [CW_W-1:0] cw
);

  // Mask rf_w, status_ld and pc_fs while stalled; pass everything else.
  always_comb begin
    cw = raw;
    if (stall) begin
      cw[CW_RF_W]                   = 1'b0;
      cw[CW_STATUS_LD]              = 1'b0;
      cw[CW_PC_FS_HI:CW_PC_FS_LO]   = PC_FS_HOLD;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: fetch/execute sequencing half of the control unit.
// Holds the instruction register, execute sub-state and status flags, picks
// the decoder control word for the current opcode class and stall-gates it.
// Optional feature macro ILLEGAL_TRAP_EN: when defined, an illegal opcode
// halts the sequencer (sticky `illegal`, left only by reset); otherwise it
// executes as an R-format instruction and `illegal` is tied low.
module control_sequencer
  import control_pkg::*;
#(
  parameter int I_W   = 32,
  parameter int CW_W  = 33,
  parameter int N_CLS = 6
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [I_W-1:0]        data_in,
  input  logic                  mem_ready,
  input  logic [4:0]            status_in,
  input  logic [N_CLS*CW_W-1:0] cw_dec,
  output logic [I_W-1:0]        ir,
  output logic [1:0]            state,
  output logic [4:0]            status,
  output logic [2:0]            cls,
  output logic [CW_W-1:0]       cw,
  output logic                  fetching,
  output logic                  illegal
);

  localparam logic [1:0] PH_FETCH = 2'b00;
  localparam logic [1:0] PH_EXEC  = 2'b01;
`ifdef ILLEGAL_TRAP_EN
  localparam logic [1:0] PH_HALT  = 2'b10;
`endif

  logic [1:0]      phase;
  logic [2:0]      raw_cls;
  logic [2:0]      exe_cls;
  logic [CW_W-1:0] raw;
  logic [CW_W-1:0] gated;
  logic            stall;
  logic            trap;

  assign raw_cls = op_class(ir[31:0]);
  // Decoder actually consulted: an unmatched opcode falls back to R.
  assign exe_cls = (raw_cls == CLS_ILLEGAL) ? CLS_R : raw_cls;

`ifdef ILLEGAL_TRAP_EN
  assign trap = (raw_cls == CLS_ILLEGAL);
  assign cls  = raw_cls;
`else
  assign trap = 1'b0;
  assign cls  = exe_cls;
`endif

  assign fetching = (phase == PH_FETCH);

  // Select the decoder control word for the current class.
  always_comb begin
    raw = '0;
    for (int k = 0; k < N_CLS; k++) begin
      if (exe_cls == 3'(k))
        raw = cw_dec[k*CW_W +: CW_W];
    end
  end

  assign stall = raw[CW_RAM_EN] & ~mem_ready;

  cw_gate #(
    .CW_W (CW_W)
  ) u_cw_gate (
    .raw   (raw),
    .stall (stall),
    .cw    (gated)
  );

  // Drive the datapath control word from the current phase.
  always_comb begin
    cw = CW_W'(FETCH_CW);
    case (phase)
      PH_EXEC: cw = trap ? CW_W'(HALT_CW) : gated;
`ifdef ILLEGAL_TRAP_EN
      PH_HALT: cw = CW_W'(HALT_CW);
`endif
      default: cw = CW_W'(FETCH_CW);
    endcase
  end

  // Phase FSM, instruction register, sub-state and status flags.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase  <= PH_FETCH;
      ir     <= '0;
      state  <= 2'b00;
      status <= 5'b00000;
    end else begin
      case (phase)
        PH_FETCH: begin
          if (mem_ready) begin
            ir    <= data_in;
            state <= 2'b00;
            phase <= PH_EXEC;
          end
        end
        PH_EXEC: begin
          if (trap) begin
`ifdef ILLEGAL_TRAP_EN
            phase <= PH_HALT;
`endif
          end else if (!stall) begin
            if (raw[CW_STATUS_LD])
              status <= status_in;
            if (raw[CW_NS_HI:CW_NS_LO] == 2'b00)
              phase <= PH_FETCH;
            else
              state <= raw[CW_NS_HI:CW_NS_LO];
          end
        end
`ifdef ILLEGAL_TRAP_EN
        PH_HALT: phase <= PH_HALT;
`endif
        default: phase <= PH_FETCH;
      endcase
    end
  end

`ifdef ILLEGAL_TRAP_EN
  // Sticky illegal-opcode flag, set when an illegal opcode reaches EXEC.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      illegal <= 1'b0;
    else if (phase == PH_EXEC && trap)
      illegal <= 1'b1;
  end
`else
  assign illegal = 1'b0;
`endif

endmodule
